core_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the NPC core. Walks each instruction through fetch, decode, execute, memory and writeback.
- Owns the instruction-memory and data-memory request/ack handshakes.
- Generates the write enables for the PC, IR and register file, and enters a terminal halt state on ebreak.
- Sits between the fetch unit, the decoder, the execute unit and the LSU; it holds no datapath state of its own.

---
 rtl/core_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_core_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core with imem/dmem handshakes.
// Optional performance counters are compiled in with `define CTRL_PERF_CNT_EN.
module core_seq_ctrl #(
    parameter int MEM_TIMEOUT   = 255,
    parameter bit RESET_PC_LOAD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_ebreak,
    input  logic        dec_illegal,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic        pc_we,
    output logic        halt,
    output logic        bus_err,
`ifdef CTRL_PERF_CNT_EN
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt,
`endif
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg;
    logic       is_load_reg;
    logic       is_store_reg;
    logic       bus_err_reg;
    logic       waiting;
    logic       timeout_hit;

    // A cycle with a request outstanding but no ack; an ack at the limit wins.
    assign waiting     = ((state_reg == S_FETCH) && !imem_ack) ||
                         ((state_reg == S_MEM)   && !dmem_ack);
    assign timeout_hit = waiting && (wait_cnt_reg == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 8'd0;
            is_load_reg  <= 1'b0;
            is_store_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_next == S_FETCH || state_next == S_MEM) && state_next != state_reg)
                wait_cnt_reg <= 8'd0;
            else if (waiting)
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            if (state_reg == S_DECODE) begin
                is_load_reg  <= dec_is_load;
                is_store_reg <= dec_is_store;
            end
            if (timeout_hit)
                bus_err_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack)         state_next = S_DECODE;
                else if (timeout_hit) state_next = S_HALT;
            end
            S_DECODE: state_next = (dec_illegal || dec_is_ebreak) ? S_HALT : S_EXEC;
            S_EXEC:   state_next = (is_load_reg || is_store_reg) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack)         state_next = is_store_reg ? S_FETCH : S_WB;
                else if (timeout_hit) state_next = S_HALT;
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        halt     = 1'b0;
        unique case (state_reg)
            // Gated by rst so the reset-vector load fires only once reset has been released.
            S_IDLE:  pc_we = RESET_PC_LOAD && !rst;
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store_reg;
                pc_we    = dmem_ack && is_store_reg;
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    assign bus_err = bus_err_reg;
    assign state_o = state_reg;

`ifdef CTRL_PERF_CNT_EN
    logic [63:0] cycle_cnt_reg;
    logic [63:0] instret_cnt_reg;

    // The launch cycle out of IDLE counts, as does the cycle that enters HALT; HALT itself is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_reg   <= 64'd0;
            instret_cnt_reg <= 64'd0;
        end else begin
            if (state_reg != S_HALT)
                cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
            if ((state_reg == S_WB) || (state_reg == S_MEM && dmem_ack && is_store_reg))
                instret_cnt_reg <= instret_cnt_reg + 64'd1;
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: ALU/load/store flows, halt behaviour, timeout boundary
// and, when CTRL_PERF_CNT_EN is defined, the performance counters.
module tb_core_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0, ir_we;
    logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_is_ebreak = 1'b0, dec_illegal = 1'b0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic        reg_we, pc_we, halt, bus_err;
    logic [2:0]  state_o;
`ifdef CTRL_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] O_IREQ = 8'h80, O_IRWE = 8'h40, O_DREQ = 8'h20, O_DWE  = 8'h10,
                           O_RWE  = 8'h08, O_PCWE = 8'h04, O_HALT = 8'h02, O_BERR = 8'h01;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                           ST_M = 3'd4, ST_WB = 3'd5, ST_H = 3'd6;

    logic [7:0] outs;
    assign outs = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halt, bus_err};

    always #5 clk = ~clk;

    core_seq_ctrl #(.MEM_TIMEOUT(4), .RESET_PC_LOAD(1'b1)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .pc_we(pc_we), .halt(halt), .bus_err(bus_err),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .state_o(state_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive acks on the falling edge, then compare state and outputs.
    task automatic cyc(input string tag, input logic ia, input logic da,
                       input logic [2:0] es, input logic [7:0] eo);
        @(negedge clk);
        imem_ack = ia;
        dmem_ack = da;
        #1;
        $display("cycle %-12s state=%0d outs=%02h", tag, state_o, outs);
        check({tag, ".state"}, 64'(state_o), 64'(es));
        check({tag, ".outs"}, 64'(outs), 64'(eo));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ebreak = 1'b0; dec_illegal = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("reset %-12s state=%0d outs=%02h", tag, state_o, outs);
        check({tag, ".rst_state"}, 64'(state_o), 64'(ST_IDLE));
        check({tag, ".rst_outs"}, 64'(outs), 64'h0);
`ifdef CTRL_PERF_CNT_EN
        check({tag, ".rst_cycle"}, cycle_cnt, 64'd0);
        check({tag, ".rst_instret"}, instret_cnt, 64'd0);
`endif
        rst = 1'b0;
        #1;
        check({tag, ".idle_pcwe"}, 64'(outs), 64'(O_PCWE));
    endtask

    task automatic alu_instr(input string tag);
        cyc({tag, ".F"}, 1'b1, 1'b0, ST_F, O_IREQ | O_IRWE);
        cyc({tag, ".D"}, 1'b0, 1'b0, ST_D, 8'h00);
        cyc({tag, ".E"}, 1'b0, 1'b0, ST_E, 8'h00);
        cyc({tag, ".WB"}, 1'b0, 1'b0, ST_WB, O_RWE | O_PCWE);
    endtask

    initial begin
        do_reset("init");

        for (int i = 0; i < 3; i++) alu_instr($sformatf("alu%0d", i));

        // Load with dmem_ack on the fourth MEM cycle: 8 cycles total.
        dec_is_load = 1'b1;
        cyc("ld.F", 1'b1, 1'b0, ST_F, O_IREQ | O_IRWE);
        cyc("ld.D", 1'b0, 1'b0, ST_D, 8'h00);
        cyc("ld.E", 1'b0, 1'b0, ST_E, 8'h00);
        dec_is_load = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("ld.M%0d", i), 1'b0, 1'b0, ST_M, O_DREQ);
        cyc("ld.Mack", 1'b0, 1'b1, ST_M, O_DREQ);
        cyc("ld.WB", 1'b0, 1'b0, ST_WB, O_RWE | O_PCWE);

        // Store acked on first MEM cycle; dmem_we must hold after the decoder input drops.
        dec_is_store = 1'b1;
        cyc("st.F", 1'b1, 1'b0, ST_F, O_IREQ | O_IRWE);
        cyc("st.D", 1'b0, 1'b0, ST_D, 8'h00);
        cyc("st.E", 1'b0, 1'b0, ST_E, 8'h00);
        dec_is_store = 1'b0;
        cyc("st.Mack", 1'b0, 1'b1, ST_M, O_DREQ | O_DWE | O_PCWE);

        // ebreak: next fetch, decode, then HALT ignoring stray acks.
        dec_is_ebreak = 1'b1;
        cyc("eb.F", 1'b1, 1'b0, ST_F, O_IREQ | O_IRWE);
        cyc("eb.D", 1'b0, 1'b0, ST_D, 8'h00);
        cyc("eb.H0", 1'b1, 1'b1, ST_H, O_HALT);
        dec_is_ebreak = 1'b0;
        cyc("eb.H1", 1'b1, 1'b0, ST_H, O_HALT);
        cyc("eb.H2", 1'b0, 1'b1, ST_H, O_HALT);

        do_reset("post_halt");

        // Fetch timeout: counter 0..4 without ack, then HALT with bus_err.
        for (int i = 0; i < 5; i++) cyc($sformatf("to.F%0d", i), 1'b0, 1'b0, ST_F, O_IREQ);
        cyc("to.H0", 1'b0, 1'b0, ST_H, O_HALT | O_BERR);
        cyc("to.H1", 1'b1, 1'b1, ST_H, O_HALT | O_BERR);

        do_reset("post_to");

        // Ack arriving exactly at the limit wins.
        for (int i = 0; i < 4; i++) cyc($sformatf("bd.F%0d", i), 1'b0, 1'b0, ST_F, O_IREQ);
        cyc("bd.Fack", 1'b1, 1'b0, ST_F, O_IREQ | O_IRWE);
        cyc("bd.D", 1'b0, 1'b0, ST_D, 8'h00);
        cyc("bd.E", 1'b0, 1'b0, ST_E, 8'h00);
        cyc("bd.WB", 1'b0, 1'b0, ST_WB, O_RWE | O_PCWE);

        // Data-side timeout on a load.
        dec_is_load = 1'b1;
        cyc("dto.F", 1'b1, 1'b0, ST_F, O_IREQ | O_IRWE);
        cyc("dto.D", 1'b0, 1'b0, ST_D, 8'h00);
        cyc("dto.E", 1'b0, 1'b0, ST_E, 8'h00);
        dec_is_load = 1'b0;
        for (int i = 0; i < 5; i++) cyc($sformatf("dto.M%0d", i), 1'b0, 1'b0, ST_M, O_DREQ);
        cyc("dto.H", 1'b0, 1'b0, ST_H, O_HALT | O_BERR);

        do_reset("post_dto");

        // Illegal instruction halts like ebreak, without bus_err.
        dec_illegal = 1'b1;
        cyc("ill.F", 1'b1, 1'b0, ST_F, O_IREQ | O_IRWE);
        cyc("ill.D", 1'b0, 1'b0, ST_D, 8'h00);
        cyc("ill.H", 1'b0, 1'b0, ST_H, O_HALT);
        dec_illegal = 1'b0;

`ifdef CTRL_PERF_CNT_EN
        do_reset("perf");
        for (int i = 0; i < 10; i++) alu_instr($sformatf("pf%0d", i));
        dec_is_ebreak = 1'b1;
        cyc("pf.ebF", 1'b1, 1'b0, ST_F, O_IREQ | O_IRWE);
        cyc("pf.ebD", 1'b0, 1'b0, ST_D, 8'h00);
        cyc("pf.H", 1'b0, 1'b0, ST_H, O_HALT);
        dec_is_ebreak = 1'b0;
        check("pf.instret", instret_cnt, 64'd10);
        check("pf.cycle", cycle_cnt, 64'd43);
        repeat (3) @(negedge clk);
        #1;
        check("pf.instret_frozen", instret_cnt, 64'd10);
        check("pf.cycle_frozen", cycle_cnt, 64'd43);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
